// File: rtl/ins_decode_queue_if.sv
// Fetch/decode-queue/register-read bus: the push side, the pop side, flush and occupancy.
// The slave modport is the queue; the master modport drives it.
interface ins_decode_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_itype;
    logic [5:0]        out_opcode;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [5:0]        out_funct;
    logic [DATA_W-1:0] out_imm_ext;
    logic [DATA_W-1:0] out_pc4;
    logic [DATA_W-1:0] out_target;
    logic              out_illegal;
    logic [PTR_W:0]    count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_itype, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm_ext, out_pc4, out_target, out_illegal, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_itype, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm_ext, out_pc4, out_target, out_illegal, count
    );
endinterface

// File: rtl/ins_decode_queue.sv
// Registered instruction-decode FIFO: decodes R/I/J fields, immediate and targets at push time.
// Define ILLEGAL_OP_CHK_EN to flag unsupported opcodes/functs as itype 3 with zeroed operands.
module ins_decode_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input logic                clk,
    input logic                rst_n,
    ins_decode_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ITYPE_R   = 2'd0;
    localparam logic [1:0] ITYPE_I   = 2'd1;
    localparam logic [1:0] ITYPE_J   = 2'd2;
    localparam logic [1:0] ITYPE_BAD = 2'd3;

    if (DATA_W != 32) begin : g_chk_width
        $error("ins_decode_queue: DATA_W must be 32");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("ins_decode_queue: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [1:0]        itype;
        logic [5:0]        opcode;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] target;
        logic              illegal;
    } dec_t;

    dec_t              r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    dec_t              w_dec;
    dec_t              w_head;
    logic [5:0]        w_opcode;
    logic [DATA_W-1:0] w_pc4;
    logic              w_push;
    logic              w_pop;
    logic              w_out_valid;
    logic              w_in_ready;

    assign w_opcode = bus.in_instr[31:26];
    assign w_pc4    = bus.in_pc + DATA_W'(4);

`ifdef ILLEGAL_OP_CHK_EN
    logic w_op_ok;
    logic w_fn_ok;
    assign w_op_ok = w_opcode inside {6'h00, [6'h02:6'h05], [6'h08:6'h0F], 6'h23, 6'h2B};
    assign w_fn_ok = bus.in_instr[5:0] inside {6'h00, 6'h02, 6'h08, [6'h20:6'h2A]};
`endif

    always_comb begin
        // NOTE: every field gets a default first so no path through the case infers a latch.
        w_dec        = '0;
        w_dec.opcode = w_opcode;
        w_dec.pc4    = w_pc4;
        case (w_opcode)
            6'h00: begin
                w_dec.itype = ITYPE_R;
                w_dec.rs    = bus.in_instr[25:21];
                w_dec.rt    = bus.in_instr[20:16];
                w_dec.rd    = bus.in_instr[15:11];
                w_dec.shamt = bus.in_instr[10:6];
                w_dec.funct = bus.in_instr[5:0];
            end
            6'h02, 6'h03: begin
                w_dec.itype  = ITYPE_J;
                w_dec.target = {w_pc4[31:28], bus.in_instr[25:0], 2'b00};
            end
            default: begin
                w_dec.itype = ITYPE_I;
                w_dec.rs    = bus.in_instr[25:21];
                w_dec.rt    = bus.in_instr[20:16];
                // Logical immediates zero-extend, lui loads the upper half, the rest sign-extend.
                case (w_opcode)
                    6'h0C, 6'h0D, 6'h0E: w_dec.imm_ext = {16'h0000, bus.in_instr[15:0]};
                    6'h0F:               w_dec.imm_ext = {bus.in_instr[15:0], 16'h0000};
                    default:             w_dec.imm_ext = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
                endcase
                w_dec.target = w_pc4 + (w_dec.imm_ext << 2);
            end
        endcase
`ifdef ILLEGAL_OP_CHK_EN
        if (!w_op_ok || ((w_opcode == 6'h00) && !w_fn_ok)) begin
            w_dec.itype   = ITYPE_BAD;
            w_dec.rs      = '0;
            w_dec.rt      = '0;
            w_dec.rd      = '0;
            w_dec.imm_ext = '0;
            w_dec.target  = '0;
            w_dec.illegal = 1'b1;
        end
`endif
    end

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot the push needs, so a full queue still accepts.
    assign w_in_ready  = (r_count < (PTR_W+1)'(DEPTH)) || w_pop;
    assign w_push      = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // NOTE: storage is cleared too so no stale decode survives a reset; it is small enough to be flops.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking updates let the pointer and count logic read pre-edge values throughout.
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_itype   = w_head.itype;
    assign bus.out_opcode  = w_head.opcode;
    assign bus.out_rs      = w_head.rs;
    assign bus.out_rt      = w_head.rt;
    assign bus.out_rd      = w_head.rd;
    assign bus.out_shamt   = w_head.shamt;
    assign bus.out_funct   = w_head.funct;
    assign bus.out_imm_ext = w_head.imm_ext;
    assign bus.out_pc4     = w_head.pc4;
    assign bus.out_target  = w_head.target;
    assign bus.out_illegal = w_head.illegal;
    assign bus.count       = r_count;
endmodule

// File: tb/tb_ins_decode_queue.sv
// Scoreboard bench for ins_decode_queue: accepted pushes queue a reference decode,
// and the DUT head is compared against the queue front on every falling edge.
module tb_ins_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]  itype;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        logic [31:0] pc4;
        logic [31:0] target;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb [$];

    ins_decode_queue_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();

    ins_decode_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [5:0] op;
        e      = '0;
        op     = ins[31:26];
        e.opcode = op;
        e.pc4  = pc + 32'd4;
        if (op == 6'h00) begin
            e.itype = 2'd0;
            e.rs    = ins[25:21];
            e.rt    = ins[20:16];
            e.rd    = ins[15:11];
            e.shamt = ins[10:6];
            e.funct = ins[5:0];
        end else if (op == 6'h02 || op == 6'h03) begin
            e.itype  = 2'd2;
            e.target = {e.pc4[31:28], ins[25:0], 2'b00};
        end else begin
            e.itype = 2'd1;
            e.rs    = ins[25:21];
            e.rt    = ins[20:16];
            if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.imm_ext = {16'h0, ins[15:0]};
            else if (op == 6'h0F)                          e.imm_ext = {ins[15:0], 16'h0};
            else                                           e.imm_ext = {{16{ins[15]}}, ins[15:0]};
            e.target = e.pc4 + {e.imm_ext[29:0], 2'b00};
        end
`ifdef ILLEGAL_OP_CHK_EN
        begin
            logic [5:0] fn;
            logic       bad;
            fn  = ins[5:0];
            bad = !((op == 6'h00) || (op >= 6'h02 && op <= 6'h05) || (op >= 6'h08 && op <= 6'h0F) ||
                    (op == 6'h23) || (op == 6'h2B));
            if (op == 6'h00 && !(fn == 6'h00 || fn == 6'h02 || fn == 6'h08 || (fn >= 6'h20 && fn <= 6'h2A)))
                bad = 1'b1;
            if (bad) begin
                e.itype   = 2'd3;
                e.rs      = '0;
                e.rt      = '0;
                e.rd      = '0;
                e.imm_ext = '0;
                e.target  = '0;
                e.illegal = 1'b1;
            end
        end
`endif
        return e;
    endfunction

    function automatic exp_t head();
        exp_t h;
        h.itype   = bus.out_itype;
        h.opcode  = bus.out_opcode;
        h.rs      = bus.out_rs;
        h.rt      = bus.out_rt;
        h.rd      = bus.out_rd;
        h.shamt   = bus.out_shamt;
        h.funct   = bus.out_funct;
        h.imm_ext = bus.out_imm_ext;
        h.pc4     = bus.out_pc4;
        h.target  = bus.out_target;
        h.illegal = bus.out_illegal;
        return h;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 15);
        case (k)
            0: begin w[31:26] = 6'h00; w[5:0] = 6'h20 + 6'($urandom_range(0, 10)); end
            1: begin w[31:26] = 6'h00; w[5:0] = 6'($urandom_range(0, 63)); end
            2:  w[31:26] = 6'h02;
            3:  w[31:26] = 6'h03;
            4:  w[31:26] = 6'h04;
            5:  w[31:26] = 6'h05;
            6:  w[31:26] = 6'h08;
            7:  w[31:26] = 6'h09;
            8:  w[31:26] = 6'h0C;
            9:  w[31:26] = 6'h0D;
            10: w[31:26] = 6'h0E;
            11: w[31:26] = 6'h0F;
            12: w[31:26] = 6'h23;
            13: w[31:26] = 6'h2B;
            default: ;
        endcase
        return w;
    endfunction

    // Scoreboard monitor: checks at the falling edge, then books what the next rising edge commits.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            logic exp_rdy;
            exp_rdy = (sb.size() < DEPTH) || ((sb.size() != 0) && bus.out_ready);
            check("count", 256'(bus.count), 256'(sb.size()));
            check("out_valid", 256'(bus.out_valid), 256'(sb.size() != 0));
            check("in_ready", 256'(bus.in_ready), 256'(exp_rdy));
            if (sb.size() != 0) check("head", 256'(head()), 256'(sb[0]));
            else                check("empty_zero", 256'(head()), 256'(0));
            if (bus.flush) begin
                sb.delete();
            end else begin
                if ((sb.size() != 0) && bus.out_ready) void'(sb.pop_front());
                if (bus.in_valid && exp_rdy) sb.push_back(model(bus.in_instr, bus.in_pc));
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 256'(bus.count), 256'(0));
        check({tag, "_valid"}, 256'(bus.out_valid), 256'(0));
        check({tag, "_ready"}, 256'(bus.in_ready), 256'(1));
        check({tag, "_fields"}, 256'(head()), 256'(0));
    endtask

    initial begin
        logic [31:0] w [DEPTH+1];
        logic [31:0] pc;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check_reset_state("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // sub $2,$8,$3
        step(1, 32'h01031022, 32'h0000_0100, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("sub_valid", 256'(bus.out_valid), 256'(1));
        check("sub_itype", 256'(bus.out_itype), 256'(0));
        check("sub_rs", 256'(bus.out_rs), 256'(8));
        check("sub_rt", 256'(bus.out_rt), 256'(3));
        check("sub_rd", 256'(bus.out_rd), 256'(2));
        check("sub_funct", 256'(bus.out_funct), 256'(6'h22));
        check("sub_pc4", 256'(bus.out_pc4), 256'(32'h104));
        check("sub_target", 256'(bus.out_target), 256'(0));
        step(0, 0, 0, 1, 0);

        // addi (sign-extended) then ori (zero-extended)
        step(1, 32'h2026FFFF, 32'h0000_0104, 0, 0);
        step(1, 32'h3408FFFF, 32'h0000_0108, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("addi_imm", 256'(bus.out_imm_ext), 256'(32'hFFFF_FFFF));
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("ori_imm", 256'(bus.out_imm_ext), 256'(32'h0000_FFFF));
        step(0, 0, 0, 1, 0);

        // jal 563 near the top of the address space
        step(1, 32'h0C000233, 32'hF000_0000, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("jal_itype", 256'(bus.out_itype), 256'(2));
        check("jal_target", 256'(bus.out_target), 256'(32'hF000_08CC));
        check("jal_regs", 256'({bus.out_rs, bus.out_rt, bus.out_rd}), 256'(0));
        step(0, 0, 0, 1, 0);

        // beq with a backward offset
        step(1, 32'h1085FFFE, 32'h0000_0200, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("beq_target", 256'(bus.out_target), 256'(32'h0000_01FC));
        step(0, 0, 0, 1, 0);

        // fill past DEPTH with the consumer stalled, then stream at full rate
        pc = 32'h0000_1000;
        for (int i = 0; i <= DEPTH; i++) w[i] = gen_instr();
        for (int i = 0; i <= DEPTH; i++) step(1, w[i], pc + 32'(4 * i), 0, 0);
        @(negedge clk);
        check("full_count", 256'(bus.count), 256'(DEPTH));
        check("full_ready", 256'(bus.in_ready), 256'(0));
        check("full_head", 256'(head()), 256'(model(w[0], pc)));
        step(1, w[DEPTH], pc + 32'(4 * DEPTH), 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, gen_instr(), pc + 32'(4 * (DEPTH + 1 + i)), 1, 0);
            @(negedge clk);
            check("stream_count", 256'(bus.count), 256'(DEPTH));
        end
        for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 1, 0);
        @(negedge clk);
        check("drain_count", 256'(bus.count), 256'(0));

        // random traffic with independent stalls on both sides (including pc wrap)
        pc = 32'hFFFF_FF00;
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), gen_instr(), pc, ($urandom_range(0, 2) != 0), 0);
            pc = pc + 32'd4;
        end
        for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 1, 0);

        // flush beats a concurrent push
        for (int i = 0; i < 3; i++) step(1, gen_instr(), 32'h0000_2000 + 32'(4 * i), 0, 0);
        step(1, gen_instr(), 32'h0000_200C, 0, 1);
        @(negedge clk);
        check("flush_ready", 256'(bus.in_ready), 256'(1));
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("flush_count", 256'(bus.count), 256'(0));
        check("flush_valid", 256'(bus.out_valid), 256'(0));

        // asynchronous reset mid-stream, then a push on the first edge after release
        step(1, gen_instr(), 32'h0000_3000, 0, 0);
        step(1, gen_instr(), 32'h0000_3004, 0, 0);
        step(0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h01031022;
        bus.in_pc    = 32'h0000_4000;
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_rst_count", 256'(bus.count), 256'(1));
        check("post_rst_pc4", 256'(bus.out_pc4), 256'(32'h0000_4004));
        step(0, 0, 0, 1, 0);

`ifdef ILLEGAL_OP_CHK_EN
        step(1, 32'hFC000000, 32'h0000_5000, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("illegal_flag", 256'(bus.out_illegal), 256'(1));
        check("illegal_itype", 256'(bus.out_itype), 256'(3));
        step(0, 0, 0, 1, 0);
`endif
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("final_count", 256'(bus.count), 256'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ins_decode_queue.md
Name: ins_decode_queue

Overview:
Registered, parametrised instruction-decode buffer that sits between instruction fetch and register read. It accepts raw instruction words with their PC over a valid/ready handshake and splits each one into R/I/J fields. Field zeroing per format is the same as in our combinational field splitter. It also extends the immediate, computes the PC+4 and jump/branch targets, and holds up to DEPTH decoded entries in FIFO order so fetch and execute can stall independently.

Parameters:
DATA_W, 32, instruction/PC width; only 32 is legal, checked by elaboration-time assertion.
DEPTH, 4, number of decoded entries held; power of two, >= 2.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous: discard all stored entries
in_valid  in  1  instruction word present
in_ready  out  1  queue can accept this cycle
in_instr  in  DATA_W  raw instruction
in_pc  in  DATA_W  address of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head this cycle
out_itype  out  2  0=R, 1=I, 2=J, 3=reserved
out_opcode  out  6  instr[31:26]
out_rs, out_rt, out_rd, out_shamt  out  5 each  register/shift fields
out_funct  out  6  instr[5:0]
out_imm_ext  out  DATA_W  extended immediate
out_pc4  out  DATA_W  pc+4
out_target  out  DATA_W  J: {pc4[31:28],addr26,2'b00}; I: pc4+(imm_ext<<2); R: 0
out_illegal  out  1  see Optional Feature
count  out  PTR_W+1  entries held

Behaviour:
- Reset (rst_n low, async): count=0, rd/wr pointers=0, all storage cleared. All out_* are 0; in_ready=1.
- Decoding is combinational on in_instr, applied at push; each entry stores the decoded bundle.
  - opcode 0 -> R: rs, rt, rd, shamt, funct from their fields; imm_ext=0.
  - opcode 2 or 3 -> J: only the 26-bit address is used. rs, rt, rd, shamt, funct and imm_ext are 0.
  - Any other opcode -> I: rs, rt, imm.
    - imm is zero-extended for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori).
    - imm is placed in bits [31:16] for 0x0F (lui).
    - All other I-type opcodes sign-extend imm.
- pc4 = in_pc+4, modulo 2^32; wraps silently. Branch target addition also wraps.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < DEPTH) || pop. A simultaneous pop frees a slot, so a full queue still accepts.
- out_valid = (count != 0). Head fields are stable while out_valid && !out_ready.
- When empty, all decoded outputs read 0.
- Push and pop in the same cycle: count unchanged and both pointers advance. At count==1 this is legal: the new entry becomes head next cycle.
- Pointers wrap modulo DEPTH.
- Latency: an instruction pushed into an empty queue appears on out_* the following cycle. There is no combinational in->out bypass.
- flush: count=0 and pointers=0 next cycle. Flush takes priority over a push and a pop in the same cycle, and the pushed word is dropped. in_ready is still computed normally during flush.
- rst_n asserted mid-operation: immediate clear regardless of the handshake. The first push is accepted on the first clk edge after rst_n deasserts.

Optional Feature:
ILLEGAL_OP_CHK_EN.
- Defined:
  - out_illegal=1 for an entry whose opcode is outside the supported set {0x00, 0x02-0x05, 0x08-0x0F, 0x23, 0x2B}.
  - Also set for opcode 0 with funct outside {0x00, 0x02, 0x08, 0x20-0x2A}.
  - Illegal entries get out_itype=3, and their rs/rt/rd/imm/target fields are 0.
  - The entry is still queued and popped normally.
- Undefined: out_illegal is tied to 0; unknown opcodes decode as I-type.

Test Plan:
- Push sub $2,$8,$3 (0x01031022) at pc 0x100 -> next cycle: out_valid=1, itype=0, rs=8, rt=3, rd=2, funct=0x22, pc4=0x104, target=0.
- Push addi $6,$1,-1 (0x2026FFFF) and ori $8,$0,0xFFFF (0x3408FFFF) -> imm_ext=0xFFFFFFFF, then 0x0000FFFF.
- Push jal 563 (0x0C000233) at pc 0xF0000000 -> itype=2, target=0xF00008CC, rs=rt=rd=0.
- Push beq $4,$5,-2 (0x1085FFFE) at pc 0x200 -> target=0x1FC.
- Hold out_ready=0 and push DEPTH+1 words -> in_ready falls after DEPTH; head unchanged.
  - Then out_ready=1 with continuous push -> one push and one pop per cycle, count stays DEPTH, order preserved.
- Fill 3 entries, assert flush with in_valid=1 -> next cycle count=0, out_valid=0.
  - Separately, pulse rst_n low mid-stream -> outputs 0 immediately.
  - Only with ILLEGAL_OP_CHK_EN: push 0xFC000000 -> out_illegal=1, itype=3.
